// File: rtl/bip_loader_pkg.sv
// Shared types and constants for the UART program loader of the accumulator CPU.
package bip_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      HI,
      LO,
      WRITE,
      CSUM,
      RUN,
      ERR
   } loaderState_e;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   localparam int unsigned OPCODE_W  = 5;
   localparam int unsigned OPERAND_W = 11;
   localparam int unsigned INSTR_W   = OPCODE_W + OPERAND_W;

   function automatic logic [INSTR_W-1:0] packWord(input logic [7:0] hiByte,
                                                   input logic [7:0] loByte);
      return {hiByte, loByte};
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Reloadable inter-byte watchdog: pulses expire on the TIMEOUT_CYC-th enabled cycle without a reload.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   logic [CntW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= CntW'(TIMEOUT_CYC);
      end else if (reload) begin
         cnt <= CntW'(TIMEOUT_CYC);
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - CntW'(1);
      end
   end

   // A reload in the same cycle always wins, so a byte landing on the last cycle is accepted.
   assign expire = enable && !reload && (cnt == CntW'(1));

endmodule

// File: rtl/bip_program_loader.sv
// UART-fed program-memory writer: parses SYNC, N, N x (hi, lo), XOR checksum, then releases the CPU.
// Build option: define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
//
// state | meaning
// IDLE  | waiting for the first SYNC_BYTE after reset
// COUNT | next byte is the word count N (0 = 256 words)
// HI    | next byte is the high byte of the current word
// LO    | next byte is the low byte of the current word
// WRITE | single-cycle program-memory write, then index advance
// CSUM  | next byte is the frame checksum
// RUN   | image good, CPU enabled; SYNC with halt restarts a load
// ERR   | checksum mismatch or timeout, CPU held; SYNC restarts a load
module bip_program_loader
   import bip_loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned DATA_W      = INSTR_W,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_done_tick,
   input  logic              halt,
   output logic              prog_we,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [DATA_W-1:0] prog_data,
   output logic              cpu_en,
   output logic              load_done,
   output logic              load_err
);

   loaderState_e state, stateNext;

   logic [7:0]        wordCount, wordCountNext;
   logic [7:0]        wordIdx, wordIdxNext;
   logic [7:0]        csum, csumNext;
   logic [7:0]        hiByte, hiByteNext;
   logic [ADDR_W-1:0] addrQ, addrNext;
   logic [DATA_W-1:0] dataQ, dataNext;
   logic [7:0]        idxInc;
   logic              isSync;
   logic              timeoutExpire;

   assign isSync = rx_done_tick && (rx_data == SYNC_BYTE);
   assign idxInc = wordIdx + 8'd1;

`ifdef LOADER_TIMEOUT_EN
   logic enterCount;
   logic tmrReload;
   logic tmrEnable;

   assign enterCount = isSync && ((state == IDLE) || (state == ERR) || ((state == RUN) && halt));
   assign tmrReload  = rx_done_tick || enterCount;
   assign tmrEnable  = (state == COUNT) || (state == HI) || (state == LO) || (state == CSUM);

   loader_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) uTimeout (
      .clk   (clk),
      .rst_n (rst_n),
      .reload(tmrReload),
      .enable(tmrEnable),
      .expire(timeoutExpire)
   );
`else
   assign timeoutExpire = (TIMEOUT_CYC == 0) ? 1'b0 : 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wordCount <= '0;
         wordIdx   <= '0;
         csum      <= '0;
         hiByte    <= '0;
         addrQ     <= '0;
         dataQ     <= '0;
      end else begin
         wordCount <= wordCountNext;
         wordIdx   <= wordIdxNext;
         csum      <= csumNext;
         hiByte    <= hiByteNext;
         addrQ     <= addrNext;
         dataQ     <= dataNext;
      end
   end

   always_comb begin
      stateNext     = state;
      wordCountNext = wordCount;
      wordIdxNext   = wordIdx;
      csumNext      = csum;
      hiByteNext    = hiByte;
      addrNext      = addrQ;
      dataNext      = dataQ;

      case (state)
         IDLE: begin
            if (isSync) stateNext = COUNT;
         end
         COUNT: begin
            if (rx_done_tick) begin
               wordCountNext = rx_data;
               csumNext      = rx_data;
               wordIdxNext   = '0;
               stateNext     = HI;
            end else if (timeoutExpire) begin
               stateNext = ERR;
            end
         end
         HI: begin
            if (rx_done_tick) begin
               hiByteNext = rx_data;
               csumNext   = csum ^ rx_data;
               stateNext  = LO;
            end else if (timeoutExpire) begin
               stateNext = ERR;
            end
         end
         LO: begin
            if (rx_done_tick) begin
               csumNext  = csum ^ rx_data;
               addrNext  = ADDR_W'(wordIdx);
               dataNext  = DATA_W'(packWord(hiByte, rx_data));
               stateNext = WRITE;
            end else if (timeoutExpire) begin
               stateNext = ERR;
            end
         end
         WRITE: begin
            // A byte arriving here belongs to whichever state we are about to enter.
            wordIdxNext = idxInc;
            if (idxInc == wordCount) begin
               if (rx_done_tick) begin
                  stateNext = (rx_data == csum) ? RUN : ERR;
               end else begin
                  stateNext = CSUM;
               end
            end else begin
               if (rx_done_tick) begin
                  hiByteNext = rx_data;
                  csumNext   = csum ^ rx_data;
                  stateNext  = LO;
               end else begin
                  stateNext = HI;
               end
            end
         end
         CSUM: begin
            if (rx_done_tick) begin
               stateNext = (rx_data == csum) ? RUN : ERR;
            end else if (timeoutExpire) begin
               stateNext = ERR;
            end
         end
         RUN: begin
            if (isSync && halt) stateNext = COUNT;
         end
         ERR: begin
            if (isSync) stateNext = COUNT;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign prog_we   = (state == WRITE);
   assign prog_addr = addrQ;
   assign prog_data = dataQ;
   assign cpu_en    = (state == RUN);
   assign load_done = (state == RUN);
   assign load_err  = (state == ERR);

endmodule

// File: tb/tb_bip_program_loader.sv
// Self-checking bench for bip_program_loader: frame table plus hand-built corner sequences.
`timescale 1ns/1ps
module tb_bip_program_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_done_tick = 1'b0;
   logic        halt = 1'b0;
   logic        prog_we;
   logic [10:0] prog_addr;
   logic [15:0] prog_data;
   logic        cpu_en;
   logic        load_done;
   logic        load_err;

   always #5 clk = ~clk;

   bip_program_loader #(
      .ADDR_W     (11),
      .TIMEOUT_CYC(100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_done_tick(rx_done_tick),
      .halt        (halt),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .cpu_en      (cpu_en),
      .load_done   (load_done),
      .load_err    (load_err)
   );

   typedef struct packed {
      logic [10:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      bit halt;
      int off;
      int len;
      bit expEn;
      bit expDone;
      bit expErr;
   } vec_t;

   int         vecCount = 0;
   int         missCount = 0;
   wr_t        expQ[$];
   logic [7:0] fb[0:37];
   vec_t       vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (prog_we === 1'b1) begin
         if (expQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected", prog_addr, prog_data);
         end else begin
            e = expQ.pop_front();
            check("wr_addr", 32'(prog_addr), 32'(e.addr));
            check("wr_data", 32'(prog_data), 32'(e.data));
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, output logic enDuring);
      @(posedge clk);
      #1;
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      enDuring = cpu_en;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      logic dummy;
      sendByte(b, dummy);
   endtask

   task automatic sendB2B(input logic [7:0] q[$]);
      @(posedge clk);
      #1;
      foreach (q[i]) begin
         rx_data      = q[i];
         rx_done_tick = 1'b1;
         @(posedge clk);
         #1;
      end
      rx_done_tick = 1'b0;
   endtask

   task automatic pushFrame(input int off);
      int n;
      n = (fb[off+1] == 8'h00) ? 256 : int'(fb[off+1]);
      for (int w = 0; w < n; w++) begin
         expQ.push_back({11'(w), fb[off+2+2*w], fb[off+3+2*w]});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      logic       en;
      logic [7:0] q[$];
      logic [7:0] cs;

      // Checksums are the XOR of N and every data byte (good first frame: 0x14).
      fb = '{8'hA5, 8'h02, 8'h08, 8'h05, 8'h18, 8'h03, 8'h14,
             8'hA5, 8'h02, 8'h08, 8'h05, 8'h18, 8'h03, 8'h1D,
             8'hA5, 8'h01, 8'h00, 8'h00, 8'h01,
             8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01,
             8'hA5, 8'h01, 8'h12, 8'h34, 8'h00,
             8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h74};
      vecs[0] = '{halt: 1'b0, off: 0,  len: 7, expEn: 1'b1, expDone: 1'b1, expErr: 1'b0};
      vecs[1] = '{halt: 1'b1, off: 7,  len: 7, expEn: 1'b0, expDone: 1'b0, expErr: 1'b1};
      vecs[2] = '{halt: 1'b0, off: 14, len: 5, expEn: 1'b1, expDone: 1'b1, expErr: 1'b0};
      vecs[3] = '{halt: 1'b1, off: 19, len: 5, expEn: 1'b1, expDone: 1'b1, expErr: 1'b0};
      vecs[4] = '{halt: 1'b1, off: 24, len: 5, expEn: 1'b0, expDone: 1'b0, expErr: 1'b1};
      vecs[5] = '{halt: 1'b0, off: 29, len: 9, expEn: 1'b1, expDone: 1'b1, expErr: 1'b0};

      #2 rst_n = 1'b0;
      #20;
      check("reset_outputs", 32'({prog_we, prog_addr, prog_data, cpu_en, load_done, load_err}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         halt = vecs[i].halt;
         pushFrame(vecs[i].off);
         for (int j = 0; j < vecs[i].len; j++) begin
            sendByte(fb[vecs[i].off + j], en);
         end
         check("en_during_csum_tick", 32'(en), 32'h0);
         check("flags_after_frame", 32'({cpu_en, load_done, load_err}),
               32'({vecs[i].expEn, vecs[i].expDone, vecs[i].expErr}));
         repeat (2) @(posedge clk);
         #1;
         check("writes_drained", 32'(expQ.size()), 32'h0);
      end

      // RUN with halt low ignores SYNC; with halt high it starts a reload.
      halt = 1'b0;
      send(8'hA5);
      send(8'h02);
      check("run_ignores_sync", 32'({cpu_en, load_done}), 32'h3);
      halt = 1'b1;
      sendByte(8'hA5, en);
      check("en_during_reload_sync", 32'(en), 32'h1);
      check("en_drops_after_sync", 32'(cpu_en), 32'h0);
      pushFrame(0);
      send(8'h02);
      send(8'h08);
      send(8'h05);
      check("we_one_cycle_after_lo", 32'(prog_we), 32'h1);
      send(8'h18);
      send(8'h03);
      sendByte(8'h14, en);
      check("en_low_in_csum_tick", 32'(en), 32'h0);
      check("en_high_after_csum", 32'(cpu_en), 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("addr_data_held", 32'({prog_addr, prog_data}), 32'({11'd1, 16'h1803}));

      // Back-to-back ticks: the byte in each WRITE cycle becomes the next hi byte or checksum.
      q = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h42};
      expQ.push_back({11'd0, 16'hABCD});
      expQ.push_back({11'd1, 16'h1234});
      sendB2B(q);
      check("b2b_run", 32'({cpu_en, load_done, load_err}), 32'h6);
      check("b2b_drained", 32'(expQ.size()), 32'h0);

      // N = 0 loads 256 words at addresses 0..255.
      q = '{8'hA5, 8'h00};
      cs = 8'h00;
      for (int w = 0; w < 256; w++) begin
         logic [7:0] hb;
         logic [7:0] lb;
         hb = 8'(w);
         lb = 8'(w * 3 + 7);
         q.push_back(hb);
         q.push_back(lb);
         cs = cs ^ hb ^ lb;
         expQ.push_back({11'(w), hb, lb});
      end
      q.push_back(cs);
      sendB2B(q);
      check("n256_run", 32'({cpu_en, load_done, load_err}), 32'h6);
      check("n256_drained", 32'(expQ.size()), 32'h0);
      check("n256_last_addr", 32'(prog_addr), 32'd255);

      // Asynchronous reset in the middle of a frame.
      send(8'hA5);
      send(8'h03);
      send(8'h12);
      #3 rst_n = 1'b0;
      #1;
      check("midframe_reset_outputs", 32'({prog_we, prog_addr, prog_data, cpu_en, load_done, load_err}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      halt = 1'b0;
      pushFrame(0);
      for (int j = 0; j < 7; j++) send(fb[j]);
      check("after_reset_run", 32'({cpu_en, load_done, load_err}), 32'h6);
      check("after_reset_drained", 32'(expQ.size()), 32'h0);

`ifdef LOADER_TIMEOUT_EN
      halt = 1'b1;
      send(8'hA5);
      send(8'h01);
      send(8'h12);
      repeat (99) @(posedge clk);
      #1;
      check("timeout_not_yet", 32'(load_err), 32'h0);
      @(posedge clk);
      #1;
      check("timeout_err", 32'({cpu_en, load_err}), 32'h1);

      expQ.push_back({11'd0, 16'h1234});
      send(8'hA5);
      send(8'h01);
      send(8'h12);
      repeat (98) @(posedge clk);
      send(8'h34);
      check("gap99_no_err", 32'(load_err), 32'h0);
      send(8'h27);
      check("gap99_run", 32'({cpu_en, load_done, load_err}), 32'h6);
      check("gap99_drained", 32'(expQ.size()), 32'h0);
`endif

      repeat (2) @(posedge clk);
      check("final_queue_empty", 32'(expQ.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
